// File: rtl/mac_accum_if.sv
// mac_accum_if: product-stream input and result-register output of the MAC back end.
interface mac_accum_if #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_prod;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;
   modport master (
      output in_valid, in_prod, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_cnt, out_ovf
   );
   modport slave (
      input  in_valid, in_prod, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_cnt, out_ovf
   );
endinterface

// File: rtl/mac_accum.sv
// mac_accum: sums signed 32-bit products into a wide clamping/wrapping accumulator and
// presents each finished group on a one-entry valid/ready result register.
module mac_accum #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8,
   parameter bit SAT   = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   mac_accum_if.slave bus
);
   typedef enum logic {IDLE, ACC} state_t;
   localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
   state_t           state;
   logic [ACC_W-1:0] acc, base, prod_x, sum_raw, sum;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, add_ovf, take;
   assign bus.in_ready = !bus.out_valid || bus.out_ready;
   assign take         = bus.in_valid && bus.in_ready && !clr;
   always_comb begin
      base    = (state == IDLE) ? '0 : acc;
      prod_x  = {{(ACC_W-32){bus.in_prod[31]}}, bus.in_prod};
      sum_raw = base + prod_x;
      // signed overflow: operands agree in sign but the result does not
      add_ovf = (base[ACC_W-1] == prod_x[ACC_W-1]) && (sum_raw[ACC_W-1] != base[ACC_W-1]);
      sum     = (add_ovf && SAT) ? (base[ACC_W-1] ? MIN_V : MAX_V) : sum_raw;
      cnt_nxt = &cnt ? cnt : cnt + 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         ovf           <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_acc   <= '0;
         bus.out_cnt   <= '0;
         bus.out_ovf   <= 1'b0;
      end else if (clr) begin
         state         <= IDLE;
         acc           <= '0;
         cnt           <= '0;
         ovf           <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
         // a closing product reloads the result register even while it drains
         if (take && bus.in_last) begin
            bus.out_acc   <= sum;
            bus.out_cnt   <= cnt_nxt;
            bus.out_ovf   <= ovf | add_ovf;
            bus.out_valid <= 1'b1;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            state         <= IDLE;
         end else if (take) begin
            acc   <= sum;
            cnt   <= cnt_nxt;
            ovf   <= ovf | add_ovf;
            state <= ACC;
         end
      end
   end
endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed and random product streams into three parameterisations,
// each checked against an exact-integer reference model.
module tb_mac_accum;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_prod = '0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;
   int          n_vec = 0;
   int          n_err = 0;
   always #5 clk = ~clk;

   mac_accum_if #(.ACC_W(40), .CNT_W(8)) ia ();
   mac_accum_if #(.ACC_W(33), .CNT_W(3)) ib ();
   mac_accum_if #(.ACC_W(33), .CNT_W(3)) ic ();
   assign ia.in_valid = in_valid;
   assign ib.in_valid = in_valid;
   assign ic.in_valid = in_valid;
   assign ia.in_prod = in_prod;
   assign ib.in_prod = in_prod;
   assign ic.in_prod = in_prod;
   assign ia.in_last = in_last;
   assign ib.in_last = in_last;
   assign ic.in_last = in_last;
   assign ia.out_ready = out_ready;
   assign ib.out_ready = out_ready;
   assign ic.out_ready = out_ready;

   mac_accum #(.ACC_W(40), .CNT_W(8), .SAT(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ia));
   mac_accum #(.ACC_W(33), .CNT_W(3), .SAT(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ib));
   mac_accum #(.ACC_W(33), .CNT_W(3), .SAT(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(ic));

   // reference model: exact integer sums checked against the representable range
   int     mw[3]  = '{40, 33, 33};
   int     mcw[3] = '{8, 3, 3};
   bit     msat[3] = '{1'b1, 1'b1, 1'b0};
   longint m_acc[3], m_oacc[3];
   int     m_cnt[3], m_ocnt[3];
   bit     m_ovf[3], m_oovf[3];
   bit     m_ov;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_acc[i] = 0; m_oacc[i] = 0; m_cnt[i] = 0; m_ocnt[i] = 0; m_ovf[i] = 0; m_oovf[i] = 0;
      end
      m_ov = 0;
   endtask

   task automatic model_step(input bit v, input logic [31:0] p, input bit l, input bit r, input bit c);
      bit acc_ok;
      acc_ok = v && (!m_ov || r) && !c;
      if (c) begin
         for (int i = 0; i < 3; i++) begin m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; end
         m_ov = 0;
         return;
      end
      if (m_ov && r) m_ov = 0;
      if (!acc_ok) return;
      for (int i = 0; i < 3; i++) begin
         longint hi, lo, s;
         bit o;
         int nc;
         hi = (longint'(1) <<< (mw[i] - 1)) - 1;
         lo = -(longint'(1) <<< (mw[i] - 1));
         s = m_acc[i] + longint'($signed(p));
         o = 0;
         if (s > hi) begin o = 1; s = msat[i] ? hi : s - (longint'(1) <<< mw[i]); end
         if (s < lo) begin o = 1; s = msat[i] ? lo : s + (longint'(1) <<< mw[i]); end
         nc = (m_cnt[i] == (1 << mcw[i]) - 1) ? m_cnt[i] : m_cnt[i] + 1;
         if (l) begin
            m_oacc[i] = s; m_ocnt[i] = nc; m_oovf[i] = m_ovf[i] | o;
            m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
         end else begin
            m_acc[i] = s; m_cnt[i] = nc; m_ovf[i] = m_ovf[i] | o;
         end
      end
      if (l) m_ov = 1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs();
      chk("a_valid", ia.out_valid, m_ov);
      chk("b_valid", ib.out_valid, m_ov);
      chk("c_valid", ic.out_valid, m_ov);
      chk("a_acc", $signed(ia.out_acc), m_oacc[0]);
      chk("b_acc", $signed(ib.out_acc), m_oacc[1]);
      chk("c_acc", $signed(ic.out_acc), m_oacc[2]);
      chk("a_cnt", ia.out_cnt, m_ocnt[0]);
      chk("b_cnt", ib.out_cnt, m_ocnt[1]);
      chk("c_cnt", ic.out_cnt, m_ocnt[2]);
      chk("a_ovf", ia.out_ovf, m_oovf[0]);
      chk("b_ovf", ib.out_ovf, m_oovf[1]);
      chk("c_ovf", ic.out_ovf, m_oovf[2]);
   endtask

   // one clock: drive at negedge, check in_ready, advance model at posedge, check outputs
   task automatic cycle(input bit v, input logic [31:0] p, input bit l, input bit r, input bit c);
      in_valid = v; in_prod = p; in_last = l; out_ready = r; clr = c;
      #1;
      chk("a_in_ready", ia.in_ready, !m_ov || r);
      chk("c_in_ready", ic.in_ready, !m_ov || r);
      @(posedge clk);
      model_step(v, p, l, r, c);
      @(negedge clk);
      chk_outputs();
   endtask

   initial begin
      model_reset();
      in_valid = 1'b1; in_prod = 32'h0000_0005; in_last = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_outputs();
      chk("rst_in_ready", ia.in_ready, 1'b1);
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk_outputs();
      // group 3, -7, 100
      cycle(1, 32'd3, 0, 1, 0);
      cycle(1, -32'sd7, 0, 1, 0);
      cycle(1, 32'd100, 1, 1, 0);
      chk("grp96_acc", $signed(ia.out_acc), 64'd96);
      chk("grp96_cnt", ia.out_cnt, 64'd3);
      // back-to-back single-term groups
      cycle(1, 32'h8000_0000, 1, 1, 0);
      chk("single_neg", $signed(ia.out_acc), -64'sh8000_0000);
      cycle(1, 32'd1, 1, 1, 0);
      chk("single_one", $signed(ia.out_acc), 64'd1);
      chk("single_cnt", ia.out_cnt, 64'd1);
      cycle(0, 32'd0, 0, 1, 0);
      // held result with back-pressure
      cycle(1, 32'd3, 0, 0, 0);
      cycle(1, -32'sd7, 0, 0, 0);
      cycle(1, 32'd100, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cycle(1, 32'd7, 1, 0, 0);
         chk("hold_acc", $signed(ia.out_acc), 64'd96);
         chk("hold_ready", ia.in_ready, 1'b0);
      end
      cycle(1, 32'd7, 1, 1, 0);
      chk("release_acc", $signed(ia.out_acc), 64'd7);
      cycle(0, 32'd0, 0, 1, 0);
      // overflow at ACC_W=33: clamp vs wrap
      cycle(1, 32'h7FFF_FFFF, 0, 1, 0);
      cycle(1, 32'h7FFF_FFFF, 0, 1, 0);
      cycle(1, 32'h7FFF_FFFF, 1, 1, 0);
      chk("sat33_acc", ib.out_acc, 64'h0_FFFF_FFFF);
      chk("sat33_ovf", ib.out_ovf, 1'b1);
      chk("wrap33_acc", ic.out_acc, 64'h1_7FFF_FFFD);
      chk("wrap33_ovf", ic.out_ovf, 1'b1);
      // abort mid-group
      cycle(1, 32'd10, 0, 1, 0);
      cycle(1, 32'd20, 0, 1, 0);
      cycle(1, 32'd99, 0, 1, 1);
      cycle(1, 32'd5, 1, 1, 0);
      chk("clr_acc", $signed(ia.out_acc), 64'd5);
      chk("clr_cnt", ia.out_cnt, 64'd1);
      // term counter saturation on the 3-bit counters
      for (int k = 0; k < 9; k++) cycle(1, 32'd1, 0, 1, 0);
      cycle(1, 32'd1, 1, 1, 0);
      chk("cnt_sat", ib.out_cnt, 64'd7);
      chk("cnt_wide", ia.out_cnt, 64'd10);
      // random traffic
      for (int k = 0; k < 400; k++) begin
         logic [31:0] p;
         p = $urandom;
         if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 1) ? 32'h7FFF_FFF0 : 32'h8000_0010;
         cycle($urandom_range(0, 3) != 0, p, $urandom_range(0, 4) == 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      end
      // asynchronous reset mid-group with a result pending
      cycle(1, 32'd9, 1, 0, 0);
      cycle(1, 32'd9, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1, 32'd4, 1, 1, 0);
      chk("post_rst_acc", $signed(ia.out_acc), 64'd4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
